psola_playback: RTL and testbench



---
 rtl/psola_playback.sv | 170 +++++++++++++++++
 tb/tb_psola_playback.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psola_playback.sv
// Double-buffered playback stage: captures PSOLA windows into two RAM banks,
// converts them to saturated 16-bit PCM and replays committed windows one
// sample per audio tick. Empty slots are played as silence (underrun).
module psola_playback #(
  parameter int MAX_EXTENDED      = 2200,
  parameter int SHIFT             = 8,
  parameter int MAX_EXTENDED_BITS = $clog2(MAX_EXTENDED)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [31:0]                  in_val,
  input  logic [MAX_EXTENDED_BITS-1:0] in_addr,
  input  logic                         in_valid,
  input  logic                         in_done,
  input  logic                         sample_tick_in,
  output logic [15:0]                  sample_out,
  output logic                         sample_valid_out,
  output logic                         underrun_out,
  output logic                         overflow_out,
  output logic [1:0]                   level_out
);

  // Lengths must hold MAX_EXTENDED itself, so they can be one bit wider than addresses.
  localparam int LEN_W     = $clog2(MAX_EXTENDED + 1);
  localparam int RAM_DEPTH = 2 * MAX_EXTENDED;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_EXTENDED);
  localparam logic [RAM_AW-1:0] BANK1_BASE = RAM_AW'(MAX_EXTENDED);

  logic [15:0] mem [RAM_DEPTH];
  logic [15:0] ram_rd_q;

  logic              write_sel_q, write_sel_d;
  logic              read_sel_q, read_sel_d;
  logic [1:0]        full_q, full_d;
  logic [LEN_W-1:0]  len0_q, len0_d, len1_q, len1_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic              done_q;
  logic [RAM_AW-1:0] rd_addr_q, rd_addr_d;
  logic              p1_valid_q, p1_valid_d, p1_silent_q, p1_silent_d;
  logic              out_valid_q, out_silent_q;
  logic              overflow_q, overflow_d;
  logic [1:0]        level_q, level_d;

  logic signed [31:0] shifted;
  logic [15:0]        conv;
  logic [LEN_W-1:0]   addr_ext, addr_len, rd_len;
  logic               wr_in_range, wr_en, done_rise;
  logic [RAM_AW-1:0]  wr_addr;

  // Scale the processed sample and clamp it into the 16-bit PCM range
  always_comb begin
    shifted = $signed(in_val) >>> SHIFT;
    if (shifted > 32'sd32767)       conv = 16'h7fff;
    else if (shifted < -32'sd32768) conv = 16'h8000;
    else                            conv = shifted[15:0];
  end

  assign addr_ext    = LEN_W'(in_addr);
  assign addr_len    = addr_ext + LEN_W'(1);
  // Addresses past the bank depth would land in the other bank, so they are ignored.
  assign wr_in_range = addr_ext < MAX_LEN;
  assign wr_en       = in_valid && wr_in_range && !full_q[write_sel_q];
  assign wr_addr     = RAM_AW'(in_addr) + (write_sel_q ? BANK1_BASE : '0);
  assign done_rise   = in_done && !done_q;
  assign rd_len      = read_sel_q ? len1_q : len0_q;

  // Bank bookkeeping: window length tracking, commit, read pointer and release
  always_comb begin
    write_sel_d = write_sel_q;
    read_sel_d  = read_sel_q;
    full_d      = full_q;
    len0_d      = len0_q;
    len1_d      = len1_q;
    rd_idx_d    = rd_idx_q;
    cur_len_d   = cur_len_q;
    overflow_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    p1_valid_d  = sample_tick_in;
    p1_silent_d = 1'b0;

    // Length follows every sample offered, even while the bank is blocked, so a
    // window arriving with both banks busy is still seen (and refused) at commit.
    if (in_valid && wr_in_range && (addr_len > cur_len_q)) cur_len_d = addr_len;

    // Commit decisions use the full flags from the start of the cycle; a release
    // in this same cycle only helps commits from the next cycle on.
    if (done_rise) begin
      cur_len_d = '0;
      if (cur_len_q != '0) begin
        if (!full_q[write_sel_q]) begin
          full_d[write_sel_q] = 1'b1;
          if (write_sel_q) len1_d = cur_len_q;
          else             len0_d = cur_len_q;
          write_sel_d = !write_sel_q;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (sample_tick_in) begin
      if (full_q[read_sel_q]) begin
        rd_addr_d = RAM_AW'(rd_idx_q) + (read_sel_q ? BANK1_BASE : '0);
        if (rd_idx_q == rd_len - LEN_W'(1)) begin
          full_d[read_sel_q] = 1'b0;
          read_sel_d         = !read_sel_q;
          rd_idx_d           = '0;
        end else begin
          rd_idx_d = rd_idx_q + LEN_W'(1);
        end
      end else begin
        p1_silent_d = 1'b1;
      end
    end

    level_d = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  end

  // Control state and the two-stage read pipeline
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      write_sel_q  <= 1'b0;
      read_sel_q   <= 1'b0;
      full_q       <= 2'b00;
      len0_q       <= '0;
      len1_q       <= '0;
      rd_idx_q     <= '0;
      cur_len_q    <= '0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
      p1_valid_q   <= 1'b0;
      p1_silent_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_silent_q <= 1'b0;
      overflow_q   <= 1'b0;
      level_q      <= 2'd0;
    end else begin
      write_sel_q  <= write_sel_d;
      read_sel_q   <= read_sel_d;
      full_q       <= full_d;
      len0_q       <= len0_d;
      len1_q       <= len1_d;
      rd_idx_q     <= rd_idx_d;
      cur_len_q    <= cur_len_d;
      done_q       <= in_done;
      rd_addr_q    <= rd_addr_d;
      p1_valid_q   <= p1_valid_d;
      p1_silent_q  <= p1_silent_d;
      out_valid_q  <= p1_valid_q;
      out_silent_q <= p1_silent_q;
      overflow_q   <= overflow_d;
      level_q      <= level_d;
    end
  end

  // Dual-port RAM: port A writes, port B reads into a registered output
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= conv;
    if (p1_valid_q && !p1_silent_q) ram_rd_q <= mem[rd_addr_q];
  end

  assign sample_out       = (out_valid_q && !out_silent_q) ? ram_rd_q : 16'd0;
  assign sample_valid_out = out_valid_q;
  assign underrun_out     = out_valid_q && out_silent_q;
  assign overflow_out     = overflow_q;
  assign level_out        = level_q;

endmodule

// File: tb/tb_psola_playback.sv
// Bench for psola_playback: directed scenarios plus randomized windows, checked
// every cycle against a window-queue reference model.
module tb_psola_playback;
  localparam int MAXE = 2200;
  localparam int SH   = 8;
  localparam int AW   = $clog2(MAXE);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [31:0]   in_val;
  logic [AW-1:0] in_addr;
  logic          in_valid, in_done, sample_tick_in;
  logic [15:0]   sample_out;
  logic          sample_valid_out, underrun_out, overflow_out;
  logic [1:0]    level_out;

  always #5 clk_in = ~clk_in;

  psola_playback #(.MAX_EXTENDED(MAXE), .SHIFT(SH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_val(in_val), .in_addr(in_addr),
    .in_valid(in_valid), .in_done(in_done), .sample_tick_in(sample_tick_in),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .underrun_out(underrun_out), .overflow_out(overflow_out), .level_out(level_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: committed windows as a FIFO of lengths plus a flat sample FIFO.
  int win_len_q[$];
  int smp_q[$];
  int cur_buf[64];
  int cur_len;
  bit prev_done;
  bit d1_v, d1_u, d2_v, d2_u;
  int d1_s, d2_s;
  int wvals[64];

  function automatic int conv(logic [31:0] v);
    int s;
    s = $signed(v) >>> SH;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    win_len_q.delete();
    smp_q.delete();
    cur_len = 0;
    prev_done = 0;
    d1_v = 0; d1_u = 0; d1_s = 0;
    d2_v = 0; d2_u = 0; d2_s = 0;
  endtask

  // One clock cycle: evaluate the model on the applied inputs, clock, then compare.
  task automatic step();
    int  n_start;
    bit  rise, ev, eu, eovf;
    int  es;
    n_start = win_len_q.size();
    eovf = 0;
    if (in_valid) begin
      if (int'(in_addr) + 1 > cur_len) cur_len = int'(in_addr) + 1;
      if (n_start < 2) cur_buf[in_addr] = conv(in_val);
    end
    rise = in_done && !prev_done;
    prev_done = in_done;
    ev = sample_tick_in; eu = 0; es = 0;
    if (sample_tick_in) begin
      if (n_start > 0) begin
        es = smp_q.pop_front();
        win_len_q[0] = win_len_q[0] - 1;
        if (win_len_q[0] == 0) void'(win_len_q.pop_front());
      end else begin
        eu = 1;
      end
    end
    if (rise) begin
      if (cur_len > 0) begin
        if (n_start < 2) begin
          win_len_q.push_back(cur_len);
          for (int i = 0; i < cur_len; i++) smp_q.push_back(cur_buf[i]);
        end else begin
          eovf = 1;
        end
      end
      cur_len = 0;
    end
    @(posedge clk_in);
    #1;
    d2_v = d1_v; d2_u = d1_u; d2_s = d1_s;
    d1_v = ev;   d1_u = eu;   d1_s = es;
    check("sample_valid", int'(sample_valid_out), int'(d2_v));
    check("underrun", int'(underrun_out), int'(d2_u));
    if (d2_v) check("sample", int'($signed(sample_out)), d2_s);
    check("overflow", int'(overflow_out), int'(eovf));
    check("level", int'(level_out), n_start);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ticks(int n);
    sample_tick_in = 1'b1;
    for (int i = 0; i < n; i++) step();
    sample_tick_in = 1'b0;
  endtask

  task automatic write_window(int len, bit rev);
    int a;
    for (int i = 0; i < len; i++) begin
      a = rev ? (len - 1 - i) : i;
      in_valid = 1'b1;
      in_addr  = AW'(a);
      in_val   = wvals[a];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic commit(bit t);
    in_done = 1'b1;
    sample_tick_in = t;
    step();
    in_done = 1'b0;
    sample_tick_in = 1'b0;
    step();
  endtask

  task automatic rand_window(int len);
    for (int i = 0; i < len; i++) wvals[i] = $urandom;
    write_window(len, 1'b0);
  endtask

  // Asynchronous reset at the current instant; outputs must drop immediately.
  task automatic do_reset();
    rst_in = 1'b1;
    in_valid = 1'b0; in_done = 1'b0; sample_tick_in = 1'b0;
    in_val = '0; in_addr = '0;
    #1;
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid_out), 0);
    check("rst_underrun", int'(underrun_out), 0);
    check("rst_overflow", int'(overflow_out), 0);
    check("rst_level", int'(level_out), 0);
    model_clear();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    int len, t;
    model_clear();
    do_reset();
    idle(2);

    // Single window with positive, negative and saturating values
    wvals[0] = 32'h0000_0100; wvals[1] = 32'h0000_0200;
    wvals[2] = 32'hFFFF_FF00; wvals[3] = 32'h7FFF_FFFF;
    write_window(4, 1'b0);
    commit(1'b0);
    ticks(4);
    idle(4);

    // Underrun with nothing committed, then past the end of a 2-sample window
    ticks(1);
    idle(3);
    wvals[0] = 32'h0000_1234; wvals[1] = 32'hFFFF_0000;
    write_window(2, 1'b0);
    commit(1'b0);
    ticks(3);
    idle(3);

    // Both banks full, third window refused, then strict playback order
    rand_window(3);
    commit(1'b0);
    rand_window(5);
    commit(1'b0);
    rand_window(2);
    commit(1'b0);
    idle(1);
    ticks(8);
    idle(3);
    ticks(1);
    idle(3);

    // Back-to-back ticks across a bank boundary
    rand_window(2);
    commit(1'b0);
    rand_window(2);
    commit(1'b0);
    ticks(4);
    idle(3);

    // in_done held high for many cycles commits once
    rand_window(2);
    in_done = 1'b1;
    idle(10);
    in_done = 1'b0;
    idle(1);
    ticks(3);
    idle(3);

    // Rising in_done with no data is ignored
    commit(1'b0);
    idle(2);

    // Saturation at both rails
    wvals[0] = 32'h8000_0000; wvals[1] = 32'h7FFF_FFFF;
    wvals[2] = 32'hFF80_0000; wvals[3] = 32'h007F_FF00;
    write_window(4, 1'b1);
    commit(1'b0);
    ticks(4);
    idle(3);

    // Randomized windows, tick patterns and commit/tick coincidences
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) wvals[i] = $urandom;
      write_window(len, 1'(($urandom_range(0, 1))));
      commit(1'($urandom_range(0, 1)));
      t = $urandom_range(0, 12);
      for (int i = 0; i < t; i++) begin
        sample_tick_in = 1'($urandom_range(0, 1));
        step();
      end
      sample_tick_in = 1'b0;
    end
    ticks(20);
    idle(3);

    // Reset in the middle of playing a full bank
    do_reset();
    idle(2);
    rand_window(6);
    commit(1'b0);
    ticks(3);
    do_reset();
    idle(3);
    ticks(1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
